// File: rtl/main_mem_ctrl_pkg.sv
// Shared global package: block/address types plus main-memory controller types.
// Ports: none (types and constants only).
// MAIN_MEM_BLOCK_ADDR_WIDTH is one bit wider than the default array index so
// that the first out-of-range block address (N_BLOCKS) is representable.
package main_mem_ctrl_pkg;

   localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 14;
   localparam int BLOCK_DATA_WIDTH          = 64;

   typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;
   typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

   typedef enum logic {IDLE, BUSY} mm_state_t;
   typedef enum logic {IC, DC}     mm_src_t;

   localparam int MM_CNT_WIDTH = 8;

endpackage

// File: rtl/mm_rr_arbiter_2.sv
// Two-way round-robin grant between icache and dcache requesters.
// Latency: combinational readies/grants; last_grant updates on the accept edge.
// Backpressure: readies drop when the controller is busy or in init.
// Ports: i_clk, i_init (sync reset), i_idle (controller can accept),
//        i_ic_valid/i_dc_valid (requests), o_ic_ready/o_dc_ready,
//        o_ic_grant/o_dc_grant (valid && ready, at most one high).
module mm_rr_arbiter_2
   import main_mem_ctrl_pkg::*;
(
   input  logic i_clk,
   input  logic i_init,
   input  logic i_idle,
   input  logic i_ic_valid,
   input  logic i_dc_valid,
   output logic o_ic_ready,
   output logic o_dc_ready,
   output logic o_ic_grant,
   output logic o_dc_grant
);

   mm_src_t r_last_grant;

   // Ready is a function of the *other* requester's valid only, so a
   // requester never sees its own valid looped back into its ready.
   assign o_ic_ready = i_idle && !i_init && (!i_dc_valid || (r_last_grant == DC));
   assign o_dc_ready = i_idle && !i_init && (!i_ic_valid || (r_last_grant == IC));

   assign o_ic_grant = i_ic_valid && o_ic_ready;
   assign o_dc_grant = i_dc_valid && o_dc_ready;

   always_ff @(posedge i_clk) begin
      if (i_init) begin
         r_last_grant <= IC;
      end else if (o_ic_grant) begin
         r_last_grant <= IC;
      end else if (o_dc_grant) begin
         r_last_grant <= DC;
      end
   end

endmodule

// File: rtl/main_mem_ctrl.sv
// Block-granular main memory responder for icache reads and dcache reads/writes.
// Latency: response LATENCY cycles after accept; one request outstanding at a time.
// Backpressure: req_ready low while busy/init; responses cannot be stalled.
// Ports: clk, init (sync reset + image load), init_main_mem_state (image),
//        ic_req_* / ic_resp_* (icache read channel),
//        dc_req_* / dc_resp_* (dcache read/write channel; writes echo wdata),
//        MAIN_MEM_OUT (live array contents).
module main_mem_ctrl
   import main_mem_ctrl_pkg::*;
#(
   parameter int LATENCY  = 4,
   parameter int N_BLOCKS = 8192
) (
   input  logic                 clk,
   input  logic                 init,
   input  block_data_t          init_main_mem_state [N_BLOCKS],

   input  logic                 ic_req_valid,
   input  main_mem_block_addr_t ic_req_addr,
   output logic                 ic_req_ready,
   output logic                 ic_resp_valid,
   output block_data_t          ic_resp_data,

   input  logic                 dc_req_valid,
   input  logic                 dc_req_wr,
   input  main_mem_block_addr_t dc_req_addr,
   input  block_data_t          dc_req_wdata,
   output logic                 dc_req_ready,
   output logic                 dc_resp_valid,
   output block_data_t          dc_resp_data,

   output block_data_t          MAIN_MEM_OUT [N_BLOCKS]
);

   localparam int IDX_W = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
   localparam logic [MAIN_MEM_BLOCK_ADDR_WIDTH:0] N_BLOCKS_W =
      (MAIN_MEM_BLOCK_ADDR_WIDTH+1)'(N_BLOCKS);
   localparam logic [MM_CNT_WIDTH-1:0] CNT_LOAD = MM_CNT_WIDTH'(LATENCY - 1);

   block_data_t          r_mem [N_BLOCKS];
   mm_state_t            r_state;
   logic [MM_CNT_WIDTH-1:0] r_cnt;
   mm_src_t              r_src;
   main_mem_block_addr_t r_addr;
   logic                 r_wr;
   block_data_t          r_wdata;

   logic                 w_ic_grant;
   logic                 w_dc_grant;
   logic                 w_in_range;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_resp;
   block_data_t          w_rdata;
   block_data_t          w_resp_data;

   mm_rr_arbiter_2 u_arb (
      .i_clk      (clk),
      .i_init     (init),
      .i_idle     (r_state == IDLE),
      .i_ic_valid (ic_req_valid),
      .i_dc_valid (dc_req_valid),
      .o_ic_ready (ic_req_ready),
      .o_dc_ready (dc_req_ready),
      .o_ic_grant (w_ic_grant),
      .o_dc_grant (w_dc_grant)
   );

   // Out-of-range addresses must never alias onto a real block, so every
   // array access is qualified by w_in_range.
   assign w_in_range = ({1'b0, r_addr} < N_BLOCKS_W);
   assign w_idx      = r_addr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (init) begin
         // Image load and FSM reset; an in-flight write is dropped here.
         r_mem   <= init_main_mem_state;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_src   <= IC;
         r_addr  <= '0;
         r_wr    <= 1'b0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ic_grant) begin
                  r_src   <= IC;
                  r_addr  <= ic_req_addr;
                  r_wr    <= 1'b0;
                  r_wdata <= '0;
                  r_cnt   <= CNT_LOAD;
                  r_state <= BUSY;
               end else if (w_dc_grant) begin
                  r_src   <= DC;
                  r_addr  <= dc_req_addr;
                  r_wr    <= dc_req_wr;
                  r_wdata <= dc_req_wdata;
                  r_cnt   <= CNT_LOAD;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // Response cycle: commit after the echo so a read in this
                  // same cycle would still see the old contents.
                  if (r_wr && w_in_range) begin
                     r_mem[w_idx] <= r_wdata;
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_resp      = (r_state == BUSY) && (r_cnt == '0);
   assign w_rdata     = w_in_range ? r_mem[w_idx] : '0;
   assign w_resp_data = r_wr ? r_wdata : w_rdata;

   assign ic_resp_valid = w_resp && (r_src == IC);
   assign dc_resp_valid = w_resp && (r_src == DC);
   assign ic_resp_data  = ic_resp_valid ? w_resp_data : '0;
   assign dc_resp_data  = dc_resp_valid ? w_resp_data : '0;

   assign MAIN_MEM_OUT = r_mem;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: u0 uses defaults (LATENCY 4, 8192 blocks),
// u1 uses LATENCY 1 with 16 blocks for the back-to-back boundary.
// Inputs change and outputs are sampled just after the falling edge.
module tb_main_mem_ctrl;
   import main_mem_ctrl_pkg::*;

   localparam int NB0 = 8192;
   localparam int NB1 = 16;
   localparam block_data_t PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 init          [2];
   logic                 ic_req_valid  [2];
   main_mem_block_addr_t ic_req_addr   [2];
   logic                 ic_req_ready  [2];
   logic                 ic_resp_valid [2];
   block_data_t          ic_resp_data  [2];
   logic                 dc_req_valid  [2];
   logic                 dc_req_wr     [2];
   main_mem_block_addr_t dc_req_addr   [2];
   block_data_t          dc_req_wdata  [2];
   logic                 dc_req_ready  [2];
   logic                 dc_resp_valid [2];
   block_data_t          dc_resp_data  [2];

   block_data_t img0 [NB0];
   block_data_t img1 [NB1];
   block_data_t mmo0 [NB0];
   block_data_t mmo1 [NB1];

   int n_checks = 0;
   int n_errors = 0;

   main_mem_ctrl #(.LATENCY(4), .N_BLOCKS(NB0)) u0 (
      .clk                 (clk),
      .init                (init[0]),
      .init_main_mem_state (img0),
      .ic_req_valid        (ic_req_valid[0]),
      .ic_req_addr         (ic_req_addr[0]),
      .ic_req_ready        (ic_req_ready[0]),
      .ic_resp_valid       (ic_resp_valid[0]),
      .ic_resp_data        (ic_resp_data[0]),
      .dc_req_valid        (dc_req_valid[0]),
      .dc_req_wr           (dc_req_wr[0]),
      .dc_req_addr         (dc_req_addr[0]),
      .dc_req_wdata        (dc_req_wdata[0]),
      .dc_req_ready        (dc_req_ready[0]),
      .dc_resp_valid       (dc_resp_valid[0]),
      .dc_resp_data        (dc_resp_data[0]),
      .MAIN_MEM_OUT        (mmo0)
   );

   main_mem_ctrl #(.LATENCY(1), .N_BLOCKS(NB1)) u1 (
      .clk                 (clk),
      .init                (init[1]),
      .init_main_mem_state (img1),
      .ic_req_valid        (ic_req_valid[1]),
      .ic_req_addr         (ic_req_addr[1]),
      .ic_req_ready        (ic_req_ready[1]),
      .ic_resp_valid       (ic_resp_valid[1]),
      .ic_resp_data        (ic_resp_data[1]),
      .dc_req_valid        (dc_req_valid[1]),
      .dc_req_wr           (dc_req_wr[1]),
      .dc_req_addr         (dc_req_addr[1]),
      .dc_req_wdata        (dc_req_wdata[1]),
      .dc_req_ready        (dc_req_ready[1]),
      .dc_resp_valid       (dc_resp_valid[1]),
      .dc_resp_data        (dc_resp_data[1]),
      .MAIN_MEM_OUT        (mmo1)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Present a request in the current cycle, confirm it is accepted, and
   // return one falling edge later with the request withdrawn.
   task automatic issue(input int u, input bit is_dc, input bit wr,
                        input main_mem_block_addr_t a, input block_data_t wd);
      if (is_dc) begin
         dc_req_valid[u] = 1'b1;
         dc_req_wr[u]    = wr;
         dc_req_addr[u]  = a;
         dc_req_wdata[u] = wd;
      end else begin
         ic_req_valid[u] = 1'b1;
         ic_req_addr[u]  = a;
      end
      #1;
      if (is_dc) check("dc_req_ready", dc_req_ready[u], 1);
      else       check("ic_req_ready", ic_req_ready[u], 1);
      @(negedge clk);
      ic_req_valid[u] = 1'b0;
      dc_req_valid[u] = 1'b0;
      dc_req_wr[u]    = 1'b0;
   endtask

   // Called in the cycle after accept; the response must appear exactly in
   // the lat-th cycle, only on the granted side, with zeros elsewhere.
   task automatic expect_resp(input int u, input bit is_dc, input block_data_t exp, input int lat);
      bit fire;
      for (int k = 1; k <= lat; k++) begin
         fire = (k == lat);
         #1;
         check("ic_resp_valid", ic_resp_valid[u], (!is_dc && fire));
         check("dc_resp_valid", dc_resp_valid[u], (is_dc && fire));
         check("ic_resp_data", ic_resp_data[u], (!is_dc && fire) ? exp : 64'h0);
         check("dc_resp_data", dc_resp_data[u], (is_dc && fire) ? exp : 64'h0);
         check("busy_ic_ready", ic_req_ready[u], 0);
         check("busy_dc_ready", dc_req_ready[u], 0);
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit g_dc;
      for (int u = 0; u < 2; u++) begin
         init[u] = 1'b0;
         ic_req_valid[u] = 1'b0; ic_req_addr[u] = '0;
         dc_req_valid[u] = 1'b0; dc_req_wr[u] = 1'b0;
         dc_req_addr[u]  = '0;   dc_req_wdata[u] = '0;
      end
      for (int i = 0; i < NB0; i++) img0[i] = '0;
      img0[0]     = 64'h0BAD;
      img0[16]    = 64'h1111;
      img0[32]    = 64'h2020;
      img0[1030]  = PAT_A5;
      for (int i = 0; i < NB1; i++) img1[i] = 64'(i * 17);

      // Reset: readies held low during init, image visible afterwards.
      @(negedge clk);
      init[0] = 1'b1; init[1] = 1'b1;
      #1;
      check("init_ic_ready", ic_req_ready[0], 0);
      check("init_dc_ready", dc_req_ready[0], 0);
      @(negedge clk);
      init[0] = 1'b0; init[1] = 1'b0;
      #1;
      check("rst_ic_ready", ic_req_ready[0], 1);
      check("rst_dc_ready", dc_req_ready[0], 1);
      check("rst_ic_resp_valid", ic_resp_valid[0], 0);
      check("rst_dc_resp_valid", dc_resp_valid[0], 0);
      check("rst_ic_resp_data", ic_resp_data[0], 0);
      check("rst_dc_resp_data", dc_resp_data[0], 0);
      check("rst_mem_406", mmo0[1030], PAT_A5);
      check("rst_mem_0", mmo0[0], 64'h0BAD);
      check("rst_u1_mem_5", mmo1[5], 64'h55);

      // Init and read.
      issue(0, 0, 0, 14'h406, '0);
      expect_resp(0, 0, PAT_A5, 4);

      // Write then read back.
      issue(0, 1, 1, 14'h10, 64'h1234);
      expect_resp(0, 1, 64'h1234, 4);
      #1;
      check("mem_10_after_wr", mmo0[16], 64'h1234);
      issue(0, 1, 0, 14'h10, '0);
      expect_resp(0, 1, 64'h1234, 4);

      // Tie arbitration from reset: DC, IC, DC, IC.
      init[0] = 1'b1;
      @(negedge clk);
      init[0] = 1'b0;
      ic_req_valid[0] = 1'b1; ic_req_addr[0] = 14'h406;
      dc_req_valid[0] = 1'b1; dc_req_addr[0] = 14'h20; dc_req_wr[0] = 1'b0;
      for (int g = 0; g < 4; g++) begin
         g_dc = (g % 2 == 0);
         #1;
         check("tie_ic_ready", ic_req_ready[0], !g_dc);
         check("tie_dc_ready", dc_req_ready[0], g_dc);
         @(negedge clk);
         expect_resp(0, g_dc, g_dc ? 64'h2020 : PAT_A5, 4);
      end
      ic_req_valid[0] = 1'b0;
      dc_req_valid[0] = 1'b0;

      // Init mid-flight drops the response and the pending write.
      issue(0, 1, 1, 14'h20, 64'hDEAD);
      @(negedge clk);
      init[0] = 1'b1;
      @(negedge clk);
      init[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("midflight_dc_resp_valid", dc_resp_valid[0], 0);
         @(negedge clk);
      end
      #1;
      check("midflight_mem_20", mmo0[32], 64'h2020);

      // Out-of-range read returns 0; out-of-range write must not alias block 0.
      issue(0, 0, 0, 14'(NB0), '0);
      expect_resp(0, 0, 64'h0, 4);
      issue(0, 1, 1, 14'(NB0), 64'hBEEF);
      expect_resp(0, 1, 64'hBEEF, 4);
      #1;
      check("oor_wr_mem_0", mmo0[0], 64'h0BAD);

      // LATENCY=1: back-to-back reads, accept every second cycle.
      issue(1, 0, 0, 14'd3, '0);
      expect_resp(1, 0, 64'h33, 1);
      issue(1, 0, 0, 14'd5, '0);
      expect_resp(1, 0, 64'h55, 1);
      issue(1, 0, 0, 14'(NB1), '0);
      expect_resp(1, 0, 64'h0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
